// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level helpers.
package aes_pkg;

   localparam int unsigned N_ROUNDS = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } aes_state_e;

   // Round constants; RCON[0] is the constant used to derive K1.
   localparam logic [9:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Round constant for a given round; zero outside rounds 0..9.
   function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
      if (rnd < 4'd10) return RCON[rnd];
      return 8'h00;
   endfunction

   // Combinational S-box lookup.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] idx;
      idx = 8'hff - x;
      return SBOX_TBL[{idx, 3'b000} +: 8];
   endfunction

   // GF(2^8) multiply by 2 and by 3 over x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return gf_mul2(b) ^ b;
   endfunction

   // Bit offset of state byte (r,c) in plaintext byte order.
   function automatic int unsigned st_lsb(input int unsigned r, input int unsigned c);
      return 8 * (r + 4 * c);
   endfunction

   // Bit offset of byte (r,c) in the key-expansion word layout.
   function automatic int unsigned rk_lsb(input int unsigned r, input int unsigned c);
      return 32 * c + 8 * (3 - r);
   endfunction

   // Reorder a round key from word layout into state byte order.
   function automatic logic [127:0] rk_to_state(input logic [127:0] rk);
      logic [127:0] s;
      s = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            s[st_lsb(r, c) +: 8] = rk[rk_lsb(r, c) +: 8];
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         final_round_i,
   output logic [127:0] state_o
);

   logic [127:0] sb;
   logic [127:0] sr;
   logic [127:0] mc;
   logic [127:0] rk;

   assign rk = rk_to_state(round_key_i);

   // SubBytes on every state byte.
   for (genvar i = 0; i < 16; i++) begin : g_sbox
      assign sb[8*i +: 8] = sbox(state_i[8*i +: 8]);
   end

   // ShiftRows then MixColumns, column by column.
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;

      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[st_lsb(r, c) +: 8] = sb[st_lsb(r, (c + r) % 4) +: 8];
      end

      assign a0 = sr[st_lsb(0, c) +: 8];
      assign a1 = sr[st_lsb(1, c) +: 8];
      assign a2 = sr[st_lsb(2, c) +: 8];
      assign a3 = sr[st_lsb(3, c) +: 8];

      assign mc[st_lsb(0, c) +: 8] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
      assign mc[st_lsb(1, c) +: 8] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
      assign mc[st_lsb(2, c) +: 8] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
      assign mc[st_lsb(3, c) +: 8] = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
   end

   // The last round skips MixColumns.
   assign state_o = (final_round_i ? sr : mc) ^ rk;

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryptor, one round per clock, driving an external key expansion.
module aes_cipher_core
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic [127:0] exp_key,
   output logic         exp_load,
   output logic [31:0]  exp_rcon,
   input  logic [127:0] round_key,
   output logic [127:0] ciphertext,
   output logic         busy,
   output logic         done
);

   localparam logic [3:0] LAST_RND = 4'(N_ROUNDS);

   aes_state_e   fsm_q,  fsm_d;
   logic [3:0]   rnd_q,  rnd_d;
   logic [127:0] blk_q,  blk_d;
   logic [127:0] key_q,  key_d;
   logic [127:0] ct_q,   ct_d;
   logic         load_q, load_d;
   logic [31:0]  rcon_q, rcon_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [127:0] round_out;

   aes_round_comb u_round (
      .state_i       (blk_q),
      .round_key_i   (round_key),
      .final_round_i (rnd_q == LAST_RND),
      .state_o       (round_out)
   );

   // Next-state, datapath updates and registered output decode.
   always_comb begin
      fsm_d = fsm_q;
      rnd_d = rnd_q;
      blk_d = blk_q;
      key_d = key_q;
      ct_d  = ct_q;

      case (fsm_q)
         ST_IDLE: begin
            if (start) begin
               fsm_d = ST_LOAD;
               blk_d = plaintext;
               key_d = key;
            end
         end
         ST_LOAD: begin
            fsm_d = ST_RUN;
            rnd_d = 4'd0;
         end
         ST_RUN: begin
            if (rnd_q > LAST_RND) begin
               fsm_d = ST_IDLE;
            end else if (rnd_q == 4'd0) begin
               blk_d = blk_q ^ rk_to_state(round_key);
               rnd_d = rnd_q + 4'd1;
            end else begin
               blk_d = round_out;
               if (rnd_q == LAST_RND) begin
                  ct_d  = round_out;
                  fsm_d = ST_DONE;
               end else begin
                  rnd_d = rnd_q + 4'd1;
               end
            end
         end
         ST_DONE: begin
            fsm_d = ST_IDLE;
         end
         default: begin
            fsm_d = ST_IDLE;
         end
      endcase

      load_d = (fsm_d == ST_LOAD);
      busy_d = (fsm_d == ST_LOAD) || (fsm_d == ST_RUN);
      done_d = (fsm_d == ST_DONE);
      rcon_d = (fsm_d == ST_RUN) ? {rcon_of(rnd_d), 24'h000000} : 32'h0;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q  <= ST_IDLE;
         rnd_q  <= 4'd0;
         blk_q  <= '0;
         key_q  <= '0;
         ct_q   <= '0;
         load_q <= 1'b0;
         rcon_q <= 32'h0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         rnd_q  <= rnd_d;
         blk_q  <= blk_d;
         key_q  <= key_d;
         ct_q   <= ct_d;
         load_q <= load_d;
         rcon_q <= rcon_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign exp_key    = key_q;
   assign exp_load   = load_q;
   assign exp_rcon   = rcon_q;
   assign ciphertext = ct_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed-vector bench for aes_cipher_core with a behavioural key-expansion model.
module tb_aes_cipher_core;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic [127:0] exp_key;
   logic         exp_load;
   logic [31:0]  exp_rcon;
   logic [127:0] round_key;
   logic [127:0] ciphertext;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] key_b, pt_b, ct_b, key_c, pt_c, ct_c;

   always #5 clk = ~clk;

   aes_cipher_core dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .plaintext  (plaintext),
      .key        (key),
      .exp_key    (exp_key),
      .exp_load   (exp_load),
      .exp_rcon   (exp_rcon),
      .round_key  (round_key),
      .ciphertext (ciphertext),
      .busy       (busy),
      .done       (done)
   );

   // GF(2^8) arithmetic used to derive the S-box algebraically.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] a);
      logic [7:0] sq, inv, b;
      sq = a; inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      if (a == 8'h00) inv = 8'h00;
      b = inv;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rc_m(input int i);
      logic [7:0] rc;
      rc = 8'h01;
      for (int j = 0; j < i; j++) rc = gmul(rc, 8'h02);
      return rc;
   endfunction

   function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = k[127:96];
      t  = {sbox_m(w3[23:16]), sbox_m(w3[15:8]), sbox_m(w3[7:0]), sbox_m(w3[31:24])}
           ^ {rc, 24'h000000};
      n0 = k[31:0] ^ t;
      n1 = k[63:32] ^ n0;
      n2 = k[95:64] ^ n1;
      n3 = k[127:96] ^ n2;
      return {n3, n2, n1, n0};
   endfunction

   function automatic logic [127:0] load_words(input logic [127:0] b);
      logic [127:0] w;
      for (int c = 0; c < 4; c++)
         w[32*c +: 32] = {b[32*c +: 8], b[32*c+8 +: 8], b[32*c+16 +: 8], b[32*c+24 +: 8]};
      return w;
   endfunction

   // Turn a FIPS hex string (byte 0 first) into bus byte order.
   function automatic logic [127:0] rev16(input logic [127:0] x);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
      return r;
   endfunction

   // Key expansion: capture on load, then one key per cycle up to K10.
   logic [127:0] mk_q   = '0;
   int           mk_idx = 10;
   always @(posedge clk) begin
      if (exp_load) begin
         mk_q   <= load_words(exp_key);
         mk_idx <= 0;
      end else if (mk_idx < 10) begin
         mk_q   <= key_next(mk_q, rc_m(mk_idx));
         mk_idx <= mk_idx + 1;
      end
   end
   assign round_key = mk_q;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"},  busy,       128'd0);
      check_eq({tag, "_done"},  done,       128'd0);
      check_eq({tag, "_load"},  exp_load,   128'd0);
      check_eq({tag, "_rcon"},  exp_rcon,   128'd0);
      check_eq({tag, "_ct"},    ciphertext, 128'd0);
      check_eq({tag, "_key"},   exp_key,    128'd0);
   endtask

   // One block from IDLE: start in cycle 0, inputs scrambled from cycle 1, done in cycle 13.
   task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct_exp);
      logic [31:0] rc_exp;
      start = 1'b1; plaintext = pt; key = k;
      check_eq("c0_busy", busy, 128'd0);
      step();
      start = 1'b0;
      plaintext = ~pt;
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      check_eq("c1_load", exp_load, 128'd1);
      check_eq("c1_busy", busy, 128'd1);
      check_eq("c1_key",  exp_key, k);
      check_eq("c1_rcon", exp_rcon, 128'd0);
      for (int cyc = 2; cyc <= 12; cyc++) begin
         step();
         plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
         rc_exp = (cyc < 12) ? {rc_m(cyc - 2), 24'h000000} : 32'h0;
         check_eq("run_busy", busy, 128'd1);
         check_eq("run_done", done, 128'd0);
         check_eq("run_load", exp_load, 128'd0);
         check_eq($sformatf("rcon_rnd%0d", cyc - 2), exp_rcon, rc_exp);
      end
      step();
      check_eq("c13_done", done, 128'd1);
      check_eq("c13_busy", busy, 128'd0);
      check_eq("c13_rcon", exp_rcon, 128'd0);
      check_eq("c13_ct",   ciphertext, ct_exp);
      step();
      check_eq("c14_done", done, 128'd0);
   endtask

   logic [127:0] v_pt [3];
   logic [127:0] v_key[3];
   logic [127:0] v_ct [3];
   bit saw_done;

   initial begin
      key_b = rev16(128'h2b7e151628aed2a6abf7158809cf4f3c);
      pt_b  = rev16(128'h3243f6a8885a308d313198a2e0370734);
      ct_b  = rev16(128'h3925841d02dc09fbdc118597196a0b32);
      key_c = rev16(128'h000102030405060708090a0b0c0d0e0f);
      pt_c  = rev16(128'h00112233445566778899aabbccddeeff);
      ct_c  = rev16(128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      rst = 1'b1; start = 1'b0; plaintext = '0; key = '0;
      step(); step();
      check_reset_outputs("rst");

      // Reset wins over a simultaneous start.
      start = 1'b1; plaintext = pt_b; key = key_b;
      step();
      check_eq("rst_start_busy", busy, 128'd0);
      check_eq("rst_start_load", exp_load, 128'd0);
      rst = 1'b0; start = 1'b0;
      step();
      check_eq("post_rst_busy", busy, 128'd0);

      run_block(pt_b, key_b, ct_b);
      run_block(pt_c, key_c, ct_c);

      // Ciphertext holds across idle time.
      saw_done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (done) saw_done = 1'b1;
      end
      check_eq("idle_no_done", 128'(saw_done), 128'd0);
      check_eq("idle_ct_hold", ciphertext, ct_c);

      // Start held high: blocks accepted at cycles 0, 14, 28 only.
      v_pt[0] = pt_b; v_key[0] = key_b; v_ct[0] = ct_b;
      v_pt[1] = pt_c; v_key[1] = key_c; v_ct[1] = ct_c;
      v_pt[2] = pt_b; v_key[2] = key_b; v_ct[2] = ct_b;
      start = 1'b1;
      for (int cyc = 0; cyc < 42; cyc++) begin
         if (cyc % 14 == 0) begin
            plaintext = v_pt[cyc / 14];
            key       = v_key[cyc / 14];
         end else begin
            plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
            key       = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         check_eq($sformatf("b2b_done_c%0d", cyc), done, 128'(cyc % 14 == 13));
         check_eq($sformatf("b2b_load_c%0d", cyc), exp_load, 128'(cyc % 14 == 1));
         check_eq($sformatf("b2b_busy_c%0d", cyc), busy,
                  128'((cyc % 14 >= 1) && (cyc % 14 <= 12)));
         if (cyc % 14 == 13)
            check_eq($sformatf("b2b_ct_blk%0d", cyc / 14), ciphertext, v_ct[cyc / 14]);
         step();
      end
      start = 1'b0;
      step();
      check_eq("b2b_end_busy", busy, 128'd0);

      // Reset asserted during rnd 5 discards the block.
      start = 1'b1; plaintext = pt_c; key = key_c;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check_eq("rnd5_busy", busy, 128'd1);
      check_eq("rnd5_rcon", exp_rcon, 128'({rc_m(5), 24'h000000}));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs("midrst");
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done || busy) saw_done = 1'b1;
      end
      check_eq("midrst_quiet", 128'(saw_done), 128'd0);

      run_block(pt_b, key_b, ct_b);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
